// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

  // Arbiter FSM: free round-robin arbitration, or host holding a lock.
  typedef enum logic {
    IDLE  = 1'b0,
    HLOCK = 1'b1
  } arb_state_t;

  // Port identifiers; also the bit positions inside a two-bit req/gnt vector.
  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_HOST = 1'b1;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin selector: a lone request wins outright, a tie goes to
// the port that was not granted most recently.
module rr_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  // One-hot pick; ties favour the port opposite to last_gnt.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last_gnt == PORT_HOST) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a core and a host/debug port onto one single-ported data memory.
// The host may lock the memory for up to LOCK_MAX consecutive grants while the
// core is waiting; without a waiting core the lock lasts as long as the host
// wants it.
//
// Handshake: a requester raises req with we/addr/wdata and holds all of them
// stable until the cycle its gnt is 1. That grant cycle is the access. A read
// granted in cycle N returns rvalid=1 with rdata in cycle N+1 on the same
// port. Keeping req high after a grant requests a fresh access.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              h_req,
  input  logic              h_we,
  input  logic              h_lock,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  output logic              mem_e,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_di,
  input  logic [DATA_W-1:0] mem_do,
  output arb_state_t        dbg_state
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_t       state;
  arb_state_t       state_next;
  logic             last_gnt;
  logic [CNT_W-1:0] lock_cnt;
  logic             rv_core;
  logic             rv_host;
  logic [1:0]       rr_gnt;
  logic             at_limit;
  logic             force_release;

  rr_pick2 u_pick (
    .req      ({h_req, c_req}),
    .last_gnt (last_gnt),
    .gnt      (rr_gnt)
  );

  assign at_limit      = (lock_cnt == CNT_W'(LOCK_MAX));
  assign force_release = at_limit && c_req;
  assign dbg_state     = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Grant decision and next state; reset masks every grant in its own cycle.
  always_comb begin
    c_gnt      = 1'b0;
    h_gnt      = 1'b0;
    state_next = state;
    if (!rst) begin
      if (state == HLOCK) begin
        if (h_req && !force_release) h_gnt = 1'b1;
        else if (c_req)              c_gnt = 1'b1;
        if (!h_lock || !h_req || force_release) state_next = IDLE;
      end else begin
        c_gnt = rr_gnt[PORT_CORE];
        h_gnt = rr_gnt[PORT_HOST];
        if (h_gnt && h_lock) state_next = HLOCK;
      end
    end
  end

  // Locked-grant counter: the entering grant counts as 1, saturates at LOCK_MAX.
  always_ff @(posedge clk) begin
    if (rst || state_next == IDLE) lock_cnt <= '0;
    else if (state == IDLE)        lock_cnt <= CNT_W'(1);
    else if (h_gnt && !at_limit)   lock_cnt <= lock_cnt + CNT_W'(1);
  end

  // Most recent winner, used to break ties.
  always_ff @(posedge clk) begin
    if (rst)        last_gnt <= PORT_HOST;
    else if (c_gnt) last_gnt <= PORT_CORE;
    else if (h_gnt) last_gnt <= PORT_HOST;
  end

  // Read-return pipe: remembers which port owns next cycle's mem_do.
  always_ff @(posedge clk) begin
    if (rst) begin
      rv_core <= 1'b0;
      rv_host <= 1'b0;
    end else begin
      rv_core <= c_gnt && !c_we;
      rv_host <= h_gnt && !h_we;
    end
  end

  // Memory-side mux from the granted port; bus is all-zero when idle.
  always_comb begin
    mem_e    = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_di   = '0;
    if (c_gnt) begin
      mem_e    = 1'b1;
      mem_we   = c_we;
      mem_addr = c_addr;
      mem_di   = c_wdata;
    end else if (h_gnt) begin
      mem_e    = 1'b1;
      mem_we   = h_we;
      mem_addr = h_addr;
      mem_di   = h_wdata;
    end
  end

  // Read data is routed only to the owning port and zeroed otherwise.
  always_comb begin
    c_rvalid = rv_core && !rst;
    h_rvalid = rv_host && !rst;
    c_rdata  = c_rvalid ? mem_do : '0;
    h_rdata  = h_rvalid ? mem_do : '0;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 4, data-memory address width; DATA_W, default 8, data width; LOCK_MAX, default 4, maximum consecutive host-locked grants.
REQ-002 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have ports c_req / c_we, input, 1 bit each: core access request and write qualifier.
REQ-005 SHALL have ports c_addr (ADDR_W) and c_wdata (DATA_W), inputs: core address and write data.
REQ-006 SHALL have ports c_gnt and c_rvalid, outputs, 1 bit each, plus c_rdata, output, DATA_W: core grant, read-data valid, read data.
REQ-007 SHALL have ports h_req, h_we, h_lock, inputs, 1 bit each, plus h_addr (ADDR_W) and h_wdata (DATA_W), inputs: host/debug requester.
REQ-008 SHALL have ports h_gnt and h_rvalid, outputs, 1 bit each, plus h_rdata, output, DATA_W: host grant, valid, read data.
REQ-009 SHALL have ports mem_e and mem_we, outputs, 1 bit each, plus mem_addr (ADDR_W) and mem_di (DATA_W), outputs: memory enable, write enable, address, write data.
REQ-010 SHALL have port mem_do, input, DATA_W: memory read data, valid one cycle after a read-enabled edge.

Function
REQ-011 SHALL grant at most one requester per cycle; c_gnt and h_gnt are combinational from req plus registered arbiter state, never both 1.
REQ-012 Granted cycle SHALL drive mem_e=1, with mem_we, mem_addr and mem_di muxed from the granted port; with no grant, mem_e=0, mem_we=0, mem_addr=0 and mem_di=0.
REQ-013 Handshake: requester SHALL hold req, we, addr and wdata stable until the cycle gnt=1; one access completes per grant cycle; if req stays high, the next cycle is a new access.
REQ-014 Reads: granted read at cycle N SHALL give x_rvalid=1 at N+1, with x_rdata=mem_do and routed to the same port; writes give no rvalid.
REQ-015 x_rdata SHALL be 0 whenever x_rvalid=0.
REQ-016 Round-robin: if only one req is high, grant it; if both are high, grant the port not granted most recently (last_gnt register, reset = host, so core wins first).
REQ-017 Lock: when h_gnt=1 and h_lock=1, the state machine SHALL move IDLE->HLOCK; in HLOCK, h_gnt=1 whenever h_req=1 and c_gnt=0.
REQ-018 HLOCK counter lock_cnt SHALL count grant cycles, starting at 1 on entry.
REQ-019 HLOCK SHALL exit to IDLE when h_lock=0, when h_req=0, or when lock_cnt==LOCK_MAX and c_req=1 (forced release); the core is then granted on the next contested cycle.
REQ-020 With c_req=0, HLOCK SHALL persist beyond LOCK_MAX, with lock_cnt saturating at LOCK_MAX.
REQ-021 A write and a read to the same address in consecutive cycles SHALL behave as memory ordering dictates; the arbiter adds no reordering or buffering.

Reset
REQ-022 rst=1 SHALL set state IDLE, last_gnt=host and lock_cnt=0.
REQ-023 rst=1 SHALL also clear the rvalid pipeline, so in that same cycle all gnt=0, mem_e=0, and both rvalid=0 / rdata=0.
REQ-024 Reset mid-read SHALL discard the pending rvalid; reset in HLOCK SHALL release the lock.
REQ-025 The first cycle after reset deassertion SHALL arbitrate normally.

Structure
REQ-026 Shared package SHALL hold: arbiter state enum (IDLE, HLOCK), port-id constants (PORT_CORE=0, PORT_HOST=1), and default ADDR_W/DATA_W.
REQ-027 SHALL contain one sub-module, rr_pick2: a 2-way round-robin selector taking req[1:0] and last_gnt and returning a one-hot gnt; the remaining logic (FSM, counter, muxes, rvalid pipe) stays in dmem_arbiter.

Verification
REQ-028 Core-only read: c_req=1, c_we=0, c_addr=3, memory[3]=0x5A -> c_gnt=1 at N, c_rvalid=1 with c_rdata=0x5A at N+1, h_* idle.
REQ-029 Contention: both req held for 4 cycles after reset -> grants alternate core, host, core, host.
REQ-030 Host write then core read: host writes 0xC3 to addr 7, then core reads addr 7 -> core sees c_rdata=0xC3.
REQ-031 Lock starvation bound: h_lock=1 and h_req=1, with c_req raised at the host's 2nd locked cycle -> host gets exactly 4 grants, then c_gnt=1 next cycle.
REQ-032 Lock without competitor: h_lock=1 for 10 cycles, c_req=0 -> h_gnt=1 all 10 cycles.
REQ-033 Reset mid-read: rst=1 on the cycle after a host read grant -> h_rvalid=0, all grants 0, and the first post-reset contested cycle grants the core.
